pipe_trace_buf: RTL and testbench

Synthesizable, parametrised capture buffer for the five-stage CPU's per-stage diagnostic signals, such as the IF PC and instruction, the MEM memory data and the WB register-write data.
- Records only qualified cycles into a circular buffer.
- Stops a programmable number of samples after a data-match trigger.
- Provides oldest-first indexed readout so on-chip or bench logic can dump a pipeline history.
- Generalises the fixed print-every-cycle monitor to NCH channels of W bits with arm, trigger and post-trigger modes.

---
 rtl/pipe_trace_buf.sv | 187 ++++++++++++++++++
 tb/tb_pipe_trace_buf.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_trace_buf.sv
// Qualified-cycle pipeline trace buffer with arm/trigger/post-trigger capture; TRACE_TSTAMP_EN adds per-entry cycle stamps.
// Readout has 1-cycle registered latency; no backpressure, every qualified sample is accepted while capturing.
module pipe_trace_buf #(
   parameter int W   = 32,
   parameter int NCH = 4,
   parameter int AW  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NCH*W-1:0]  ch_data,
   input  logic [NCH-1:0]    ch_valid,
   input  logic              arm,
   input  logic              abort,
   input  logic [NCH-1:0]    trig_mask,
   input  logic [W-1:0]      trig_value,
   input  logic [AW-1:0]     post_cnt,
   input  logic [AW-1:0]     rd_idx,
   output logic [NCH*W-1:0]  rd_data,
   output logic [NCH-1:0]    rd_valid,
   output logic [31:0]       rd_tstamp,
   output logic [AW:0]       count,
   output logic [AW-1:0]     trig_idx,
   output logic              armed,
   output logic              triggered,
   output logic              done
);
   localparam int DEPTH = 1 << AW;
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_POST  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]     count_q, count_d;
   logic [AW-1:0]   trig_ptr_q, trig_ptr_d;
   logic [AW-1:0]   post_q, post_d;
   logic            triggered_q, triggered_d;
   logic [NCH*W-1:0] rd_data_q, rd_data_d;
   logic [NCH-1:0]  rd_valid_q, rd_valid_d;

   logic [NCH*W-1:0] mem_dat_q [DEPTH];
   logic [NCH-1:0]   mem_vld_q [DEPTH];

   logic            hit;
   logic            qual;
   logic            we;
   logic [AW-1:0]   oldest;
   logic [AW-1:0]   rd_addr;
   logic            in_range;

   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (trig_mask[i] && ch_valid[i] && (ch_data[i*W +: W] == trig_value))
            hit = 1'b1;
      end
   end

   assign qual = ((state_q == S_ARMED) || (state_q == S_POST)) && (|ch_valid);

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      trig_ptr_d  = trig_ptr_q;
      post_d      = post_q;
      triggered_d = triggered_q;
      we          = 1'b0;
      if (abort) begin
         state_d     = S_IDLE;
         triggered_d = 1'b0;
      end else if (arm) begin
         // An AW-bit post count can never exceed DEPTH-1, so the trigger entry always survives.
         state_d     = S_ARMED;
         wr_ptr_d    = '0;
         count_d     = '0;
         triggered_d = 1'b0;
         post_d      = post_cnt;
      end else if (qual) begin
         we       = 1'b1;
         wr_ptr_d = wr_ptr_q + 1'b1;
         if (count_q != FULL)
            count_d = count_q + 1'b1;
         if (state_q == S_ARMED) begin
            if (hit) begin
               triggered_d = 1'b1;
               trig_ptr_d  = wr_ptr_q;
               state_d     = (post_q == '0) ? S_DONE : S_POST;
            end
         end else begin
            post_d = post_q - 1'b1;
            if (post_q == AW'(1))
               state_d = S_DONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         trig_ptr_q  <= '0;
         post_q      <= '0;
         triggered_q <= 1'b0;
         rd_data_q   <= '0;
         rd_valid_q  <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         trig_ptr_q  <= trig_ptr_d;
         post_q      <= post_d;
         triggered_q <= triggered_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (we) begin
         mem_dat_q[wr_ptr_q] <= ch_data;
         mem_vld_q[wr_ptr_q] <= ch_valid;
      end
   end

   // Once full, the next write slot is also the oldest entry.
   assign oldest   = (count_q == FULL) ? wr_ptr_q : '0;
   assign rd_addr  = oldest + rd_idx;
   assign in_range = ({1'b0, rd_idx} < count_q);

   always_comb begin
      rd_data_d  = '0;
      rd_valid_d = '0;
      if (in_range) begin
         rd_data_d  = mem_dat_q[rd_addr];
         rd_valid_d = mem_vld_q[rd_addr];
      end
   end

`ifdef TRACE_TSTAMP_EN
   logic [31:0] tsc_q, tsc_d;
   logic [31:0] rd_tstamp_q, rd_tstamp_d;
   logic [31:0] mem_ts_q [DEPTH];

   always_comb begin
      tsc_d = tsc_q + 32'd1;
      if (arm && !abort)
         tsc_d = '0;
      rd_tstamp_d = '0;
      if (in_range)
         rd_tstamp_d = mem_ts_q[rd_addr];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tsc_q       <= '0;
         rd_tstamp_q <= '0;
      end else begin
         tsc_q       <= tsc_d;
         rd_tstamp_q <= rd_tstamp_d;
      end
   end

   always_ff @(posedge clk) begin
      if (we)
         mem_ts_q[wr_ptr_q] <= tsc_q;
   end

   assign rd_tstamp = rd_tstamp_q;
`else
   assign rd_tstamp = '0;
`endif

   assign rd_data   = rd_data_q;
   assign rd_valid  = rd_valid_q;
   assign count     = count_q;
   assign trig_idx  = trig_ptr_q - oldest;
   assign armed     = (state_q == S_ARMED) || (state_q == S_POST);
   assign triggered = triggered_q;
   assign done      = (state_q == S_DONE);
endmodule

// File: tb/tb_pipe_trace_buf.sv
// Bench for pipe_trace_buf: directed scenarios plus random traffic against a queue-based history model.
module tb_pipe_trace_buf;
   localparam int W = 32, NCH = 4, AW = 4, DEPTH = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NCH*W-1:0]  ch_data = '0;
   logic [NCH-1:0]    ch_valid = '0;
   logic              arm = 1'b0;
   logic              abort = 1'b0;
   logic [NCH-1:0]    trig_mask = '0;
   logic [W-1:0]      trig_value = '0;
   logic [AW-1:0]     post_cnt = '0;
   logic [AW-1:0]     rd_idx = '0;
   logic [NCH*W-1:0]  rd_data;
   logic [NCH-1:0]    rd_valid;
   logic [31:0]       rd_tstamp;
   logic [AW:0]       count;
   logic [AW-1:0]     trig_idx;
   logic              armed, triggered, done;

   pipe_trace_buf #(.W(W), .NCH(NCH), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .ch_data(ch_data), .ch_valid(ch_valid),
      .arm(arm), .abort(abort), .trig_mask(trig_mask), .trig_value(trig_value),
      .post_cnt(post_cnt), .rd_idx(rd_idx), .rd_data(rd_data), .rd_valid(rd_valid),
      .rd_tstamp(rd_tstamp), .count(count), .trig_idx(trig_idx), .armed(armed),
      .triggered(triggered), .done(done)
   );

   always #5 clk = ~clk;

   typedef enum {M_IDLE, M_ARMED, M_POST, M_DONE} mode_t;
   mode_t        mode = M_IDLE;
   logic [127:0] qd[$];
   logic [3:0]   qv[$];
   logic [31:0]  qt[$];
   int           total = 0, trig_abs = 0, rem = 0, post_l = 0;
   bit           trg = 0;
   logic [31:0]  tsc = '0;
   int           tests = 0, fails = 0;
   logic [31:0]  ts_a;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mode = M_IDLE; qd.delete(); qv.delete(); qt.delete();
      total = 0; trg = 0; tsc = '0; rem = 0;
   endtask

   // One clock: predict from the specification's rules, step the DUT, compare everything.
   task automatic cyc();
      logic [127:0] e_rd;
      logic [3:0]   e_rv;
      logic [31:0]  e_ts;
      bit           hit;
      e_rd = '0; e_rv = '0; e_ts = '0;
      if (rd_idx < qd.size()) begin
         e_rd = qd[rd_idx]; e_rv = qv[rd_idx]; e_ts = qt[rd_idx];
      end
`ifndef TRACE_TSTAMP_EN
      e_ts = '0;
`endif
      hit = 0;
      for (int i = 0; i < NCH; i++)
         if (trig_mask[i] && ch_valid[i] && ch_data[i*W +: W] == trig_value) hit = 1;
      if (abort) begin
         mode = M_IDLE; trg = 0;
      end else if (arm) begin
         qd.delete(); qv.delete(); qt.delete();
         total = 0; trg = 0; post_l = int'(post_cnt); mode = M_ARMED;
      end else if ((mode == M_ARMED || mode == M_POST) && ch_valid != 0) begin
         qd.push_back(ch_data); qv.push_back(ch_valid); qt.push_back(tsc);
         total++;
         if (qd.size() > DEPTH) begin
            void'(qd.pop_front()); void'(qv.pop_front()); void'(qt.pop_front());
         end
         if (mode == M_ARMED) begin
            if (hit) begin
               trg = 1; trig_abs = total - 1; rem = post_l;
               mode = (post_l > 0) ? M_POST : M_DONE;
            end
         end else begin
            rem--;
            if (rem == 0) mode = M_DONE;
         end
      end
      tsc = (arm && !abort) ? 32'd0 : tsc + 32'd1;
      @(posedge clk); #1;
      arm = 1'b0; abort = 1'b0;
      chk("armed", armed, (mode == M_ARMED || mode == M_POST));
      chk("done", done, (mode == M_DONE));
      chk("triggered", triggered, trg);
      chk("count", count, qd.size());
      chk("rd_data", rd_data, e_rd);
      chk("rd_valid", rd_valid, e_rv);
      chk("rd_tstamp", rd_tstamp, e_ts);
      if (trg) chk("trig_idx", trig_idx, trig_abs - (total - qd.size()));
   endtask

   task automatic smp(input logic [31:0] d0, input logic [3:0] v, input logic [31:0] d2);
      ch_data = {$urandom(), d2, $urandom(), d0};
      ch_valid = v;
      cyc();
   endtask

   task automatic idle(input int n);
      ch_valid = '0;
      repeat (n) cyc();
   endtask

   task automatic do_arm(input logic [3:0] pc, input logic [3:0] m, input logic [31:0] v);
      post_cnt = pc; trig_mask = m; trig_value = v; ch_valid = '0; arm = 1'b1;
      cyc();
   endtask

   initial begin
      // Reset held with the clock running
      repeat (3) @(posedge clk);
      #1;
      chk("rst_done", done, 1'b0);
      chk("rst_armed", armed, 1'b0);
      chk("rst_count", count, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_trig_idx", trig_idx, 0);
      rst_n = 1'b1;
      ch_valid = 4'hF;
      repeat (3) cyc();
      chk("no_arm_count", count, 0);

      // Basic trigger
      do_arm(4'd2, 4'b0001, 32'h10);
      for (int k = 1; k <= 7; k++) smp(32'(4 * k), 4'hF, 32'h0);
      chk("basic_done", done, 1'b1);
      chk("basic_count", count, 6);
      chk("basic_trig_idx", trig_idx, 3);
      ch_valid = '0;
      for (int i = 0; i < 6; i++) begin
         rd_idx = AW'(i);
         cyc();
         chk("basic_rd", rd_data[31:0], 32'(4 * (i + 1)));
      end
      rd_idx = 4'd10;
      cyc();
      chk("rd_out_of_range", rd_data, 0);

      // Qualification gaps
      do_arm(4'd2, 4'b0001, 32'h10);
      for (int k = 1; k <= 5; k++) begin
         smp((k < 3) ? 32'(4 * k) : 32'(4 * (k + 1)), 4'b0001, 32'h0);
         if (k == 4) chk("gap_not_done", done, 1'b0);
         if (k < 5) idle(3);
      end
      chk("gap_done", done, 1'b1);
      chk("gap_count", count, 5);
`ifdef TRACE_TSTAMP_EN
      rd_idx = 4'd0; cyc(); ts_a = rd_tstamp;
      rd_idx = 4'd1; cyc();
      chk("gap_tstamp_delta", rd_tstamp - ts_a, 32'd4);
`endif

      // Wrap: trigger on sample 20 with three post samples
      do_arm(4'd3, 4'b0001, 32'd20);
      for (int k = 1; k <= 24; k++) smp(32'(k), 4'b0001, 32'h0);
      chk("wrap_count", count, 16);
      chk("wrap_trig_idx", trig_idx, 12);
      ch_valid = '0;
      rd_idx = 4'd0; cyc();
      chk("wrap_rd0", rd_data[31:0], 32'd8);
      rd_idx = 4'd15; cyc();
      chk("wrap_rd15", rd_data[31:0], 32'd23);

      // Masking and multi-channel
      do_arm(4'd1, 4'b0100, 32'hAB);
      smp(32'hAB, 4'hF, 32'h0);
      chk("mask_ch0", triggered, 1'b0);
      smp(32'h0, 4'b1011, 32'hAB);
      chk("mask_ch2_invalid", triggered, 1'b0);
      smp(32'h0, 4'b0100, 32'hAB);
      chk("mask_ch2_hit", triggered, 1'b1);

      // Control edge cases
      arm = 1'b1; abort = 1'b1; ch_valid = '0;
      cyc();
      chk("arm_abort_idle", armed, 1'b0);
      do_arm(4'd3, 4'b0001, 32'd5);
      smp(32'd5, 4'b0001, 32'h0);
      smp(32'd6, 4'b0001, 32'h0);
      chk("post_armed", armed, 1'b1);
      post_cnt = 4'd3; arm = 1'b1; ch_valid = 4'b0001;
      cyc();
      chk("rearm_count", count, 0);
      chk("rearm_triggered", triggered, 1'b0);
      smp(32'd5, 4'b0001, 32'h0);
      smp(32'd7, 4'b0001, 32'h0);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_count", count, 0);
      chk("async_rst_armed", armed, 1'b0);
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      ch_valid = '0;
      cyc();

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         arm = ($urandom_range(0, 29) == 0);
         abort = ($urandom_range(0, 79) == 0);
         ch_valid = 4'($urandom_range(0, 15));
         for (int i = 0; i < NCH; i++) ch_data[i*W +: W] = $urandom_range(1, 6);
         if (arm) begin
            trig_value = $urandom_range(1, 6);
            trig_mask = 4'($urandom_range(0, 15));
            post_cnt = 4'($urandom_range(0, 15));
         end
         rd_idx = 4'($urandom_range(0, 15));
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
